// File: rtl/register_file_pkg.sv
// Shared constants and types for the register-file write arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package register_file_pkg;

   localparam int RF_WIDTH    = 32;  // data width of one register
   localparam int RF_ADDR_W   = 5;   // register address width
   localparam int RF_NUM_REGS = 32;  // architectural registers, r0 is hard zero

   localparam int ZERO_REG = 0;

   // Sequencer phases: INIT clears r1..rN-1, RUN serves the requesters.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Encoding of the last-grant flag.
   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; purely combinational, one-hot grant.
// Latency: 0 cycles (grant follows req/last_grant in the same cycle).
// Backpressure: no grant while i_enable is low; requests simply wait.
// Ports: i_req[0]=A, i_req[1]=B; i_last_grant 0=A last, 1=B last;
//        i_enable gates all grants; o_grant one-hot (or zero).
module rr_arbiter_2
   import register_file_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   input  logic       i_enable,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = 2'b00;
      if (i_enable) begin
         if (i_req == 2'b11) begin
            // Contention: the side that did not win last time goes now.
            if (i_last_grant == GRANT_B) begin
               o_grant = 2'b01;
            end else begin
               o_grant = 2'b10;
            end
         end else begin
            o_grant = i_req;
         end
      end
   end

endmodule

// File: rtl/register_file_write_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback
// after an init pass that zeroes r1..NUM_REGS-1. Latency: accept -> write 1 cycle.
// Backpressure: readys low during INIT; in RUN one requester accepted per cycle.
// Ports: clock/reset (sync, active-low); a_*/b_* valid-ready requesters;
//        Reg_Write_o/Write_Register_o/Write_Data_o registered write port;
//        init_done_o init pass finished; last_grant_o 0=A, 1=B.
module register_file_write_arbiter
   import register_file_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_REGS = RF_NUM_REGS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              a_valid_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [WIDTH-1:0]  a_data_i,
   output logic              a_ready_o,
   input  logic              b_valid_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [WIDTH-1:0]  b_data_i,
   output logic              b_ready_o,
   output logic              Reg_Write_o,
   output logic [ADDR_W-1:0] Write_Register_o,
   output logic [WIDTH-1:0]  Write_Data_o,
   output logic              init_done_o,
   output logic              last_grant_o
);

   // One extra bit so the pointer can step past the last register; the
   // out-of-range value marks the idle cycle that hands over to RUN.
   localparam int               PTR_W     = ADDR_W + 1;
   localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REGS - 1);

   state_t              r_state;
   logic [PTR_W-1:0]    r_init_ptr;
   logic                r_reg_write;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [WIDTH-1:0]    r_wr_data;
   logic                r_last_grant;

   state_t              w_state_nxt;
   logic [PTR_W-1:0]    w_init_ptr_nxt;
   logic                w_reg_write_nxt;
   logic [ADDR_W-1:0]   w_wr_addr_nxt;
   logic [WIDTH-1:0]    w_wr_data_nxt;
   logic                w_last_grant_nxt;

   logic [1:0]          w_grant;
   logic                w_accept_a;
   logic                w_accept_b;

   // Grant depends only on valids, last grant and phase, never on payload.
   rr_arbiter_2 u_rr_arbiter_2 (
      .i_req        ({b_valid_i, a_valid_i}),
      .i_last_grant (r_last_grant),
      .i_enable     (r_state == ST_RUN),
      .o_grant      (w_grant)
   );

   assign w_accept_a = w_grant[0] & a_valid_i;
   assign w_accept_b = w_grant[1] & b_valid_i;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= ST_INIT;
         r_init_ptr   <= PTR_FIRST;
         r_reg_write  <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_last_grant <= GRANT_B;   // A gets first priority after reset
      end else begin
         r_state      <= w_state_nxt;
         r_init_ptr   <= w_init_ptr_nxt;
         r_reg_write  <= w_reg_write_nxt;
         r_wr_addr    <= w_wr_addr_nxt;
         r_wr_data    <= w_wr_data_nxt;
         r_last_grant <= w_last_grant_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_init_ptr_nxt   = r_init_ptr;
      w_reg_write_nxt  = 1'b0;
      w_wr_addr_nxt    = r_wr_addr;
      w_wr_data_nxt    = r_wr_data;
      w_last_grant_nxt = r_last_grant;

      unique case (r_state)
         ST_INIT: begin
            if (r_init_ptr <= PTR_LAST) begin
               w_reg_write_nxt = 1'b1;
               w_wr_addr_nxt   = r_init_ptr[ADDR_W-1:0];
               w_wr_data_nxt   = '0;
               w_init_ptr_nxt  = r_init_ptr + PTR_W'(1);
            end else begin
               // The last init write is on the port now; next edge opens RUN.
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_accept_a) begin
               // Writes to r0 are accepted (ready seen) but never reach the file.
               w_reg_write_nxt  = (a_addr_i != ADDR_W'(ZERO_REG));
               w_wr_addr_nxt    = a_addr_i;
               w_wr_data_nxt    = a_data_i;
               w_last_grant_nxt = GRANT_A;
            end else if (w_accept_b) begin
               w_reg_write_nxt  = (b_addr_i != ADDR_W'(ZERO_REG));
               w_wr_addr_nxt    = b_addr_i;
               w_wr_data_nxt    = b_data_i;
               w_last_grant_nxt = GRANT_B;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   assign a_ready_o        = w_grant[0];
   assign b_ready_o        = w_grant[1];
   assign Reg_Write_o      = r_reg_write;
   assign Write_Register_o = r_wr_addr;
   assign Write_Data_o     = r_wr_data;
   assign init_done_o      = (r_state == ST_RUN);
   assign last_grant_o     = r_last_grant;

endmodule

// File: tb/tb_register_file_write_arbiter.sv
// Self-checking bench for register_file_write_arbiter: directed scenarios
// followed by random valid/ready traffic against a cycle-count reference model.
module tb_register_file_write_arbiter;

   localparam int WIDTH    = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              a_valid_i = 1'b0;
   logic [ADDR_W-1:0] a_addr_i = '0;
   logic [WIDTH-1:0]  a_data_i = '0;
   logic              a_ready_o;
   logic              b_valid_i = 1'b0;
   logic [ADDR_W-1:0] b_addr_i = '0;
   logic [WIDTH-1:0]  b_data_i = '0;
   logic              b_ready_o;
   logic              Reg_Write_o;
   logic [ADDR_W-1:0] Write_Register_o;
   logic [WIDTH-1:0]  Write_Data_o;
   logic              init_done_o;
   logic              last_grant_o;

   register_file_write_arbiter #(
      .WIDTH    (WIDTH),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .a_valid_i        (a_valid_i),
      .a_addr_i         (a_addr_i),
      .a_data_i         (a_data_i),
      .a_ready_o        (a_ready_o),
      .b_valid_i        (b_valid_i),
      .b_addr_i         (b_addr_i),
      .b_data_i         (b_data_i),
      .b_ready_o        (b_ready_o),
      .Reg_Write_o      (Reg_Write_o),
      .Write_Register_o (Write_Register_o),
      .Write_Data_o     (Write_Data_o),
      .init_done_o      (init_done_o),
      .last_grant_o     (last_grant_o)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model. m_cnt = rising edges since reset release:
   // 1..NUM_REGS-1 are init writes, NUM_REGS is the handover edge, and the
   // port is open to requesters from then on.
   int                m_cnt;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [WIDTH-1:0]  m_data;
   logic              m_done;
   logic              m_last;
   logic              g_a = 1'b0;
   logic              g_b = 1'b0;

   task automatic model_reset();
      m_cnt  = 0;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_done = 1'b0;
      m_last = 1'b1;
   endtask

   task automatic check_outputs();
      check_val("Reg_Write",      Reg_Write_o,      m_we);
      check_val("Write_Register", Write_Register_o, m_addr);
      check_val("Write_Data",     Write_Data_o,     m_data);
      check_val("init_done",      init_done_o,      m_done);
      check_val("last_grant",     last_grant_o,     m_last);
   endtask

   // Called at posedge+1 with inputs already driven for this cycle.
   task automatic step();
      logic win_a;
      logic win_b;
      #1;
      win_a = 1'b0;
      win_b = 1'b0;
      if (m_cnt >= NUM_REGS) begin
         if (a_valid_i && b_valid_i) begin
            if (m_last) win_a = 1'b1;
            else        win_b = 1'b1;
         end else if (a_valid_i) begin
            win_a = 1'b1;
         end else if (b_valid_i) begin
            win_b = 1'b1;
         end
      end
      g_a = win_a;
      g_b = win_b;
      check_val("a_ready", a_ready_o, win_a);
      check_val("b_ready", b_ready_o, win_b);

      if (!reset) begin
         model_reset();
      end else if (m_cnt < NUM_REGS - 1) begin
         m_cnt++;
         m_we   = 1'b1;
         m_addr = ADDR_W'(m_cnt);
         m_data = '0;
      end else if (m_cnt == NUM_REGS - 1) begin
         m_cnt++;
         m_we   = 1'b0;
         m_done = 1'b1;
      end else if (win_a) begin
         m_we   = (a_addr_i != 0);
         m_addr = a_addr_i;
         m_data = a_data_i;
         m_last = 1'b0;
      end else if (win_b) begin
         m_we   = (b_addr_i != 0);
         m_addr = b_addr_i;
         m_data = b_data_i;
         m_last = 1'b1;
      end else begin
         m_we = 1'b0;
      end

      @(posedge clock);
      #1;
      check_outputs();
   endtask

   // New random request only when the side is idle or was just accepted.
   task automatic rand_inputs();
      if (!a_valid_i || g_a) begin
         a_valid_i = ($urandom_range(0, 3) != 0);
         a_addr_i  = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
         a_data_i  = $urandom;
      end
      if (!b_valid_i || g_b) begin
         b_valid_i = ($urandom_range(0, 3) != 0);
         b_addr_i  = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
         b_data_i  = $urandom;
      end
   endtask

   initial begin
      // Reset with A already requesting r5; it must wait out the init pass.
      reset     = 1'b0;
      a_valid_i = 1'b1;
      a_addr_i  = 5'd5;
      a_data_i  = 32'hDEADBEEF;
      repeat (2) @(posedge clock);
      #1;
      model_reset();
      check_outputs();
      step();

      // Init pass: 31 zero writes, handover edge, then A accepted.
      reset = 1'b1;
      repeat (NUM_REGS) step();
      step();
      a_valid_i = 1'b0;

      // B alone targeting r0: accepted but not written.
      b_valid_i = 1'b1;
      b_addr_i  = 5'd0;
      b_data_i  = 32'hFFFFFFFF;
      step();

      // Sustained contention: r3,r4,r3,r4.
      a_valid_i = 1'b1; a_addr_i = 5'd3; a_data_i = 32'h11;
      b_valid_i = 1'b1; b_addr_i = 5'd4; b_data_i = 32'h22;
      repeat (4) step();

      // Same destination from both sides, A has priority.
      a_addr_i = 5'd7; a_data_i = 32'hA;
      b_addr_i = 5'd7; b_data_i = 32'hB;
      step();
      a_valid_i = 1'b0;
      step();
      b_valid_i = 1'b0;
      step();

      // Random traffic with a reset in the middle of RUN.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) reset = 1'b0;
         if (i == 202) reset = 1'b1;
         rand_inputs();
         step();
      end

      // Reset on the 10th init cycle, held for 2 cycles, full pass afterwards.
      a_valid_i = 1'b0;
      b_valid_i = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
      repeat (9) step();
      reset = 1'b0;
      repeat (2) step();
      reset = 1'b1;
      repeat (NUM_REGS + 2) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
